// File: rtl/exec_sequencer.sv
// Multi-cycle execute/memory/writeback sequencer for an RV32I/RV64I core.
// Takes one decoded control word per handshake and reports next_pc on a done pulse.
module exec_sequencer #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned DMEM_AW = 7
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [3:0]          inst_type_i,
  input  logic [2:0]          fun3_i,
  input  logic                fun7_i,
  input  logic [REG_AW-1:0]   rd_i,
  input  logic [REG_AW-1:0]   rs1_i,
  input  logic [REG_AW-1:0]   rs2_i,
  input  logic [XLEN-1:0]     pc_i,
  input  logic [XLEN-1:0]     imm_i,
  output logic [REG_AW-1:0]   rf_rd_addr0_o,
  output logic [REG_AW-1:0]   rf_rd_addr1_o,
  input  logic [XLEN-1:0]     rf_rd_dout0_i,
  input  logic [XLEN-1:0]     rf_rd_dout1_i,
  output logic                rf_we_o,
  output logic [REG_AW-1:0]   rf_wr_addr_o,
  output logic [XLEN-1:0]     rf_wr_din_o,
  output logic [XLEN-1:0]     fu_a_o,
  output logic [XLEN-1:0]     fu_b_o,
  output logic [3:0]          fu_fs_o,
  input  logic [XLEN-1:0]     fu_s_i,
  input  logic [3:0]          fu_flags_i,
  output logic [DMEM_AW-1:0]  dm_rd_addr_o,
  output logic [DMEM_AW-1:0]  dm_wr_addr_o,
  input  logic [XLEN-1:0]     dm_rd_dout_i,
  output logic                dm_we_o,
  output logic [XLEN-1:0]     dm_wr_din_o,
  output logic [XLEN/8-1:0]   dm_wr_be_o,
  output logic                done_o,
  output logic [XLEN-1:0]     next_pc_o,
  output logic                illegal_o
);
  localparam int unsigned Nb  = XLEN / 8;
  localparam int unsigned Off = $clog2(Nb);

  localparam logic [3:0] TLoad  = 4'd0;
  localparam logic [3:0] TImm   = 4'd1;
  localparam logic [3:0] TStore = 4'd2;
  localparam logic [3:0] TReg   = 4'd3;
  localparam logic [3:0] TLui   = 4'd4;
  localparam logic [3:0] TAuipc = 4'd5;
  localparam logic [3:0] TBrnch = 4'd6;
  localparam logic [3:0] TJalr  = 4'd7;
  localparam logic [3:0] TJal   = 4'd8;

  typedef enum logic [2:0] {StIdle, StOpnd, StExec, StWb, StMemRd, StLdWb, StMemWr} state_e;

  state_e               state_q;
  logic                 in_ready_q, done_q, illegal_q, rf_we_q, dm_we_q;
  logic [3:0]           itype_q, fu_fs_q;
  logic [2:0]           fun3_q;
  logic                 fun7_q;
  logic [REG_AW-1:0]    rd_q, rf_rd_addr0_q, rf_rd_addr1_q, rf_wr_addr_q;
  logic [XLEN-1:0]      pc_q, imm_q, rs2d_q, fu_a_q, fu_b_q, rf_wr_din_q, next_pc_q, dm_wr_din_q;
  logic [Off-1:0]       ld_off_q;
  logic [DMEM_AW-1:0]   dm_rd_addr_q, dm_wr_addr_q;
  logic [Nb-1:0]        dm_wr_be_q;

  logic [Off-1:0]       off, align_mask;
  logic [Nb-1:0]        be_mask, st_be;
  logic [DMEM_AW-1:0]   word_addr;
  logic [XLEN-1:0]      pc4, st_din, ld_lane, ld_ext;
  logic                 aligned, ld_ok, st_ok, br_taken, br_illegal;

  always_comb begin
    off       = fu_s_i[Off-1:0];
    word_addr = fu_s_i[DMEM_AW+Off-1:Off];
    pc4       = pc_q + XLEN'(4);
    for (int i = 0; i < int'(Off); i++) align_mask[i] = (i < int'(fun3_q[1:0]));
    for (int i = 0; i < int'(Nb); i++) be_mask[i] = (i < (1 << fun3_q[1:0]));
    aligned = (off & align_mask) == '0;
    st_be   = be_mask << off;
    st_din  = rs2d_q << {off, 3'b000};

    case (fun3_q)
      3'd0, 3'd1, 3'd2, 3'd4, 3'd5: ld_ok = aligned;
      3'd3, 3'd6:                   ld_ok = aligned && (XLEN == 64);
      default:                      ld_ok = 1'b0;
    endcase
    case (fun3_q)
      3'd0, 3'd1, 3'd2: st_ok = aligned;
      3'd3:             st_ok = aligned && (XLEN == 64);
      default:          st_ok = 1'b0;
    endcase

    // fu_flags = {Z, C, N, V}; C set means no borrow
    br_illegal = 1'b0;
    case (fun3_q)
      3'd0:    br_taken = fu_flags_i[3];
      3'd1:    br_taken = !fu_flags_i[3];
      3'd4:    br_taken = fu_flags_i[1] ^ fu_flags_i[0];
      3'd5:    br_taken = !(fu_flags_i[1] ^ fu_flags_i[0]);
      3'd6:    br_taken = !fu_flags_i[2];
      3'd7:    br_taken = fu_flags_i[2];
      default: begin
        br_taken   = 1'b0;
        br_illegal = 1'b1;
      end
    endcase

    ld_lane = dm_rd_dout_i >> {ld_off_q, 3'b000};
    case (fun3_q)
      3'd0:    ld_ext = XLEN'($signed(ld_lane[7:0]));
      3'd4:    ld_ext = XLEN'(ld_lane[7:0]);
      3'd1:    ld_ext = XLEN'($signed(ld_lane[15:0]));
      3'd5:    ld_ext = XLEN'(ld_lane[15:0]);
      3'd2:    ld_ext = XLEN'($signed(ld_lane[31:0]));
      3'd6:    ld_ext = XLEN'(ld_lane[31:0]);
      default: ld_ext = ld_lane;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      in_ready_q    <= 1'b1;
      done_q        <= 1'b0;
      illegal_q     <= 1'b0;
      rf_we_q       <= 1'b0;
      dm_we_q       <= 1'b0;
      itype_q       <= '0;
      fu_fs_q       <= '0;
      fun3_q        <= '0;
      fun7_q        <= 1'b0;
      rd_q          <= '0;
      rf_rd_addr0_q <= '0;
      rf_rd_addr1_q <= '0;
      rf_wr_addr_q  <= '0;
      pc_q          <= '0;
      imm_q         <= '0;
      rs2d_q        <= '0;
      fu_a_q        <= '0;
      fu_b_q        <= '0;
      rf_wr_din_q   <= '0;
      next_pc_q     <= '0;
      dm_wr_din_q   <= '0;
      ld_off_q      <= '0;
      dm_rd_addr_q  <= '0;
      dm_wr_addr_q  <= '0;
      dm_wr_be_q    <= '0;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      rf_we_q   <= 1'b0;
      dm_we_q   <= 1'b0;
      unique case (state_q)
        StIdle: if (in_valid_i) begin
          itype_q       <= inst_type_i;
          fun3_q        <= fun3_i;
          fun7_q        <= fun7_i;
          rd_q          <= rd_i;
          pc_q          <= pc_i;
          imm_q         <= imm_i;
          rf_rd_addr0_q <= rs1_i;
          rf_rd_addr1_q <= rs2_i;
          in_ready_q    <= 1'b0;
          state_q       <= StOpnd;
        end
        StOpnd: begin
          case (itype_q)
            TAuipc, TJal: fu_a_q <= pc_q;
            TLui:         fu_a_q <= '0;
            default:      fu_a_q <= rf_rd_dout0_i;
          endcase
          fu_b_q <= (itype_q == TReg || itype_q == TBrnch) ? rf_rd_dout1_i : imm_q;
          case (itype_q)
            TReg:    fu_fs_q <= {fun7_q, fun3_q};
            TImm:    fu_fs_q <= {(fun3_q == 3'd5) & fun7_q, fun3_q};
            TBrnch:  fu_fs_q <= 4'b1000;
            default: fu_fs_q <= 4'b0000;
          endcase
          rs2d_q  <= rf_rd_dout1_i;
          state_q <= StExec;
        end
        StExec: begin
          ld_off_q     <= off;
          next_pc_q    <= pc4;
          rf_wr_addr_q <= rd_q;
          state_q      <= StWb;
          if (itype_q > TJal) begin
            illegal_q <= 1'b1;
            done_q    <= 1'b1;
          end else begin
            case (itype_q)
              TLoad: begin
                if (ld_ok) begin
                  dm_rd_addr_q <= word_addr;
                  state_q      <= StMemRd;
                end else begin
                  illegal_q <= 1'b1;
                  done_q    <= 1'b1;
                end
              end
              TStore: begin
                dm_wr_addr_q <= word_addr;
                dm_wr_din_q  <= st_din;
                dm_wr_be_q   <= st_ok ? st_be : '0;
                dm_we_q      <= st_ok;
                illegal_q    <= !st_ok;
                done_q       <= 1'b1;
                state_q      <= StMemWr;
              end
              TBrnch: begin
                illegal_q <= br_illegal;
                if (br_taken) next_pc_q <= pc_q + imm_q;
                done_q <= 1'b1;
              end
              default: begin
                rf_we_q     <= rd_q != '0;
                rf_wr_din_q <= (itype_q == TJal || itype_q == TJalr) ? pc4 : fu_s_i;
                if (itype_q == TJalr) next_pc_q <= fu_s_i & ~XLEN'(1);
                else if (itype_q == TJal) next_pc_q <= fu_s_i;
                done_q <= 1'b1;
              end
            endcase
          end
        end
        StMemRd: begin
          rf_we_q <= rd_q != '0;
          done_q  <= 1'b1;
          state_q <= StLdWb;
        end
        default: begin
          in_ready_q <= 1'b1;
          state_q    <= StIdle;
        end
      endcase
    end
  end

  assign in_ready_o    = in_ready_q;
  assign rf_rd_addr0_o = rf_rd_addr0_q;
  assign rf_rd_addr1_o = rf_rd_addr1_q;
  assign rf_we_o       = rf_we_q;
  assign rf_wr_addr_o  = rf_wr_addr_q;
  // Load data arrives one cycle after the address, so it bypasses the output register
  assign rf_wr_din_o   = (state_q == StLdWb) ? ld_ext : rf_wr_din_q;
  assign fu_a_o        = fu_a_q;
  assign fu_b_o        = fu_b_q;
  assign fu_fs_o       = fu_fs_q;
  assign dm_rd_addr_o  = dm_rd_addr_q;
  assign dm_wr_addr_o  = dm_wr_addr_q;
  assign dm_we_o       = dm_we_q;
  assign dm_wr_din_o   = dm_wr_din_q;
  assign dm_wr_be_o    = dm_wr_be_q;
  assign done_o        = done_q;
  assign next_pc_o     = next_pc_q;
  assign illegal_o     = illegal_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Scoreboard bench for exec_sequencer: directed control words, expectations queued at issue
// and checked by a monitor on every done pulse.
module tb_exec_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [3:0]  inst_type;
  logic [2:0]  fun3;
  logic        fun7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] pc, imm;
  logic [4:0]  rf_rd_addr0, rf_rd_addr1, rf_wr_addr;
  logic [31:0] rf_rd_dout0, rf_rd_dout1, rf_wr_din;
  logic        rf_we;
  logic [31:0] fu_a, fu_b, fu_s;
  logic [3:0]  fu_fs, fu_flags;
  logic [32:0] fu_sub;
  logic [6:0]  dm_rd_addr, dm_wr_addr;
  logic [31:0] dm_rd_dout, dm_wr_din;
  logic        dm_we;
  logic [3:0]  dm_wr_be;
  logic        done, illegal;
  logic [31:0] next_pc;

  logic [31:0] rf  [32];
  logic [31:0] mem [128];

  always #5 clk = ~clk;

  exec_sequencer dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .inst_type_i(inst_type), .fun3_i(fun3), .fun7_i(fun7), .rd_i(rd), .rs1_i(rs1),
    .rs2_i(rs2), .pc_i(pc), .imm_i(imm), .rf_rd_addr0_o(rf_rd_addr0),
    .rf_rd_addr1_o(rf_rd_addr1), .rf_rd_dout0_i(rf_rd_dout0), .rf_rd_dout1_i(rf_rd_dout1),
    .rf_we_o(rf_we), .rf_wr_addr_o(rf_wr_addr), .rf_wr_din_o(rf_wr_din), .fu_a_o(fu_a),
    .fu_b_o(fu_b), .fu_fs_o(fu_fs), .fu_s_i(fu_s), .fu_flags_i(fu_flags),
    .dm_rd_addr_o(dm_rd_addr), .dm_wr_addr_o(dm_wr_addr), .dm_rd_dout_i(dm_rd_dout),
    .dm_we_o(dm_we), .dm_wr_din_o(dm_wr_din), .dm_wr_be_o(dm_wr_be), .done_o(done),
    .next_pc_o(next_pc), .illegal_o(illegal)
  );

  assign rf_rd_dout0 = rf[rf_rd_addr0];
  assign rf_rd_dout1 = rf[rf_rd_addr1];

  // FunctionUnit model: ADD, SUB, anything else XOR; flags always from A-B
  always_comb begin
    fu_sub = {1'b0, fu_a} + {1'b0, ~fu_b} + 33'd1;
    case (fu_fs)
      4'h0:    fu_s = fu_a + fu_b;
      4'h8:    fu_s = fu_sub[31:0];
      default: fu_s = fu_a ^ fu_b;
    endcase
    fu_flags = {fu_sub[31:0] == 32'd0, fu_sub[32], fu_sub[31],
                (fu_a[31] != fu_b[31]) && (fu_sub[31] != fu_a[31])};
  end

  always @(posedge clk) dm_rd_dout <= mem[dm_rd_addr];

  typedef struct {
    string       tag;
    int          lat;
    logic        ill;
    logic [31:0] npc;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [3:0]  fs;
    logic        chk_rd;
    logic [6:0]  rda;
    logic        dmwe;
    logic [6:0]  dma;
    logic [3:0]  be;
    logic [31:0] dmd;
  } exp_t;

  exp_t exp_q[$];
  exp_t me;
  int checks = 0, errors = 0;
  int cyc = 0, hs_cyc = 0, hs_cnt = 0;

  function automatic exp_t mk(string tag, int lat, logic ill, logic [31:0] npc, logic we,
                              logic [4:0] wa, logic [31:0] wd, logic [3:0] fs);
    exp_t e;
    e.tag = tag; e.lat = lat; e.ill = ill; e.npc = npc; e.we = we; e.wa = wa; e.wd = wd;
    e.fs = fs; e.chk_rd = 1'b0; e.rda = '0; e.dmwe = 1'b0; e.dma = '0; e.be = '0; e.dmd = '0;
    return e;
  endfunction

  task automatic chk(string tag, string field, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=%0h required=%0h", tag, field, act, req);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (in_valid && in_ready) begin
        hs_cyc = cyc;
        hs_cnt++;
      end
      if ((rf_we || dm_we) && !done) chk("mon", "stray_write", 32'd1, 32'd0);
      if (done) begin
        if (exp_q.size() == 0) chk("mon", "unexpected_done", 32'd1, 32'd0);
        else begin
          me = exp_q.pop_front();
          chk(me.tag, "latency", 32'(cyc - hs_cyc), 32'(me.lat));
          chk(me.tag, "illegal", {31'd0, illegal}, {31'd0, me.ill});
          chk(me.tag, "next_pc", next_pc, me.npc);
          chk(me.tag, "fu_fs", {28'd0, fu_fs}, {28'd0, me.fs});
          chk(me.tag, "rf_we", {31'd0, rf_we}, {31'd0, me.we});
          if (me.we) begin
            chk(me.tag, "rf_wr_addr", {27'd0, rf_wr_addr}, {27'd0, me.wa});
            chk(me.tag, "rf_wr_din", rf_wr_din, me.wd);
          end
          chk(me.tag, "dm_we", {31'd0, dm_we}, {31'd0, me.dmwe});
          if (me.dmwe) begin
            chk(me.tag, "dm_wr_addr", {25'd0, dm_wr_addr}, {25'd0, me.dma});
            chk(me.tag, "dm_wr_be", {28'd0, dm_wr_be}, {28'd0, me.be});
            chk(me.tag, "dm_wr_din", dm_wr_din, me.dmd);
          end
          if (me.chk_rd) chk(me.tag, "dm_rd_addr", {25'd0, dm_rd_addr}, {25'd0, me.rda});
        end
      end
    end
  end

  task automatic issue(input logic [3:0] t, input logic [2:0] f3, input logic f7,
                       input logic [4:0] rd_v, input logic [4:0] rs1_v, input logic [4:0] rs2_v,
                       input logic [31:0] pc_v, input logic [31:0] imm_v, input exp_t e,
                       input bit push, input int hold);
    int k = 0;
    @(posedge clk);
    #1;
    inst_type = t; fun3 = f3; fun7 = f7; rd = rd_v; rs1 = rs1_v; rs2 = rs2_v;
    pc = pc_v; imm = imm_v; in_valid = 1'b1;
    if (push) exp_q.push_back(e);
    while (!in_ready && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (!in_ready) begin
      chk(e.tag, "accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      repeat (hold) @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    int k = 0;
    while ((exp_q.size() != 0 || !in_ready) && k < 30) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      chk("wait", "done_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic run(input logic [3:0] t, input logic [2:0] f3, input logic f7,
                     input logic [4:0] rd_v, input logic [4:0] rs1_v, input logic [4:0] rs2_v,
                     input logic [31:0] pc_v, input logic [31:0] imm_v, input exp_t e);
    issue(t, f3, f7, rd_v, rs1_v, rs2_v, pc_v, imm_v, e, 1'b1, 0);
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int h0;
    in_valid = 0; inst_type = 0; fun3 = 0; fun7 = 0; rd = 0; rs1 = 0; rs2 = 0; pc = 0; imm = 0;
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    for (int i = 0; i < 128; i++) mem[i] = 32'd0;
    mem[7'h40] = 32'h80FF_1234;
    rf[1] = 32'd5;      rf[2] = 32'd7;  rf[4] = 32'h100; rf[6] = 32'hABCD;
    rf[7] = 32'hFFFF_FFFF; rf[8] = 32'd1; rf[9] = 32'h41;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", "in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset", "done", {31'd0, done}, 32'd0);
    chk("reset", "rf_we", {31'd0, rf_we}, 32'd0);
    chk("reset", "dm_we", {31'd0, dm_we}, 32'd0);
    chk("reset", "illegal", {31'd0, illegal}, 32'd0);
    chk("reset", "next_pc", next_pc, 32'd0);
    rst_n = 1'b1;

    // Abort an ADD while it sits in EXEC
    e = mk("abort", 3, 0, 32'h104, 1, 3, 32'd12, 4'h0);
    issue(4'd3, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'h100, 32'd0, e, 1'b0, 0);
    @(posedge clk);
    #1 chk("abort", "pre_reset_fu_a", fu_a, 32'd5);
    #1 rst_n = 1'b0;
    #1;
    chk("abort", "in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort", "fu_a", fu_a, 32'd0);
    chk("abort", "rf_rd_addr0", {27'd0, rf_rd_addr0}, 32'd0);
    chk("abort", "done", {31'd0, done}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort", "idle_after", {31'd0, in_ready}, 32'd1);

    run(4'd3, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'h100, 32'd0,
        mk("add", 3, 0, 32'h104, 1, 3, 32'd12, 4'h0));
    run(4'd3, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'h100, 32'd0,
        mk("sub", 3, 0, 32'h104, 1, 3, 32'hFFFF_FFFE, 4'h8));
    run(4'd1, 3'd0, 1'b1, 5'd4, 5'd1, 5'd0, 32'h100, 32'h10,
        mk("addi", 3, 0, 32'h104, 1, 4, 32'h15, 4'h0));
    run(4'd1, 3'd5, 1'b1, 5'd4, 5'd1, 5'd0, 32'h100, 32'd3,
        mk("imm_f5", 3, 0, 32'h104, 1, 4, 32'd6, 4'hD));
    run(4'd4, 3'd0, 1'b0, 5'd10, 5'd1, 5'd0, 32'h100, 32'h1234_5000,
        mk("lui", 3, 0, 32'h104, 1, 10, 32'h1234_5000, 4'h0));
    run(4'd5, 3'd0, 1'b0, 5'd10, 5'd1, 5'd0, 32'h100, 32'h1000,
        mk("auipc", 3, 0, 32'h104, 1, 10, 32'h1100, 4'h0));

    e = mk("lb", 4, 0, 32'h104, 1, 5, 32'hFFFF_FF80, 4'h0);
    e.chk_rd = 1; e.rda = 7'h40;
    run(4'd0, 3'd0, 1'b0, 5'd5, 5'd4, 5'd0, 32'h100, 32'd3, e);
    e = mk("lbu", 4, 0, 32'h104, 1, 5, 32'h80, 4'h0);
    e.chk_rd = 1; e.rda = 7'h40;
    run(4'd0, 3'd4, 1'b0, 5'd5, 5'd4, 5'd0, 32'h100, 32'd3, e);
    e = mk("lh", 4, 0, 32'h104, 1, 5, 32'hFFFF_80FF, 4'h0);
    e.chk_rd = 1; e.rda = 7'h40;
    run(4'd0, 3'd1, 1'b0, 5'd5, 5'd4, 5'd0, 32'h100, 32'd2, e);
    run(4'd0, 3'd2, 1'b0, 5'd5, 5'd4, 5'd0, 32'h100, 32'd2,
        mk("lw_misaligned", 3, 1, 32'h104, 0, 0, 0, 4'h0));

    e = mk("sh", 3, 0, 32'h104, 0, 0, 0, 4'h0);
    e.dmwe = 1; e.dma = 7'h40; e.be = 4'b1100; e.dmd = 32'hABCD_0000;
    run(4'd2, 3'd1, 1'b0, 5'd0, 5'd4, 5'd6, 32'h100, 32'd2, e);
    run(4'd2, 3'd1, 1'b0, 5'd0, 5'd4, 5'd6, 32'h100, 32'd1,
        mk("sh_misaligned", 3, 1, 32'h104, 0, 0, 0, 4'h0));
    e = mk("sb", 3, 0, 32'h104, 0, 0, 0, 4'h0);
    e.dmwe = 1; e.dma = 7'h40; e.be = 4'b1000; e.dmd = 32'hCD00_0000;
    run(4'd2, 3'd0, 1'b0, 5'd0, 5'd4, 5'd6, 32'h100, 32'd3, e);

    run(4'd6, 3'd4, 1'b0, 5'd0, 5'd7, 5'd8, 32'h20, 32'h10,
        mk("blt", 3, 0, 32'h30, 0, 0, 0, 4'h8));
    run(4'd6, 3'd6, 1'b0, 5'd0, 5'd7, 5'd8, 32'h20, 32'h10,
        mk("bltu", 3, 0, 32'h24, 0, 0, 0, 4'h8));
    run(4'd6, 3'd0, 1'b0, 5'd0, 5'd8, 5'd8, 32'h20, 32'h10,
        mk("beq", 3, 0, 32'h30, 0, 0, 0, 4'h8));
    run(4'd6, 3'd2, 1'b0, 5'd0, 5'd7, 5'd8, 32'h20, 32'h10,
        mk("br_f3_2", 3, 1, 32'h24, 0, 0, 0, 4'h8));
    run(4'd7, 3'd0, 1'b0, 5'd1, 5'd9, 5'd0, 32'h20, 32'd0,
        mk("jalr", 3, 0, 32'h40, 1, 1, 32'h24, 4'h0));
    run(4'd8, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h20, 32'h100,
        mk("jal", 3, 0, 32'h120, 1, 1, 32'h24, 4'h0));

    run(4'd9, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'h100, 32'd0,
        mk("type9", 3, 1, 32'h104, 0, 0, 0, 4'h0));
    run(4'd3, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'h100, 32'd0,
        mk("add_rd0", 3, 0, 32'h104, 0, 0, 0, 4'h0));

    h0 = hs_cnt;
    issue(4'd3, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'h100, 32'd0,
          mk("held", 3, 0, 32'h104, 1, 3, 32'd12, 4'h0), 1'b1, 2);
    wait_done();
    repeat (3) @(negedge clk);
    chk("held", "accepts", 32'(hs_cnt - h0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
Multi-cycle execute/memory/writeback sequencer for the RV32I core. It is the successor to the single-cycle operand-select datapath. It accepts one decoded control word per valid/ready handshake and reads operands from the register file. It then drives the FunctionUnit, performs aligned byte/half/word data-memory access with byte enables, writes back results, and reports next_pc. Width and memory depth are parametrised, and it adds a handshake, branch resolution, load extension and illegal-op detection.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
REG_AW, 5, register-file address width.
DMEM_AW, 7, data-memory word-address width.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
in_valid  in  1  control word valid.
in_ready  out  1  high only in IDLE.
inst_type  in  4  0 load, 1 imm, 2 store, 3 reg, 4 lui, 5 auipc, 6 brnch, 7 jalr, 8 jal.
fun3  in  3  RISC-V funct3.
fun7  in  1  funct7 bit 5.
rd, rs1, rs2  in  REG_AW each  register indices.
pc, imm  in  XLEN each  instruction PC and sign-extended immediate.
rf_rd_addr0, rf_rd_addr1  out  REG_AW  read addresses for rs1 and rs2.
rf_rd_dout0, rf_rd_dout1  in  XLEN  combinational read data.
rf_we  out  1  write enable.
rf_wr_addr  out  REG_AW  write address.
rf_wr_din  out  XLEN  write data.
fu_a, fu_b  out  XLEN  FunctionUnit operands.
fu_fs  out  4  FunctionUnit select.
fu_s  in  XLEN  FunctionUnit result.
fu_flags  in  4  {Z,C,N,V}; C=1 means no borrow on SUB.
dm_rd_addr, dm_wr_addr  out  DMEM_AW  word addresses.
dm_rd_dout  in  XLEN  synchronous read data, valid 1 cycle after the address.
dm_we  out  1  write enable.
dm_wr_din  out  XLEN  lane-aligned write data.
dm_wr_be  out  XLEN/8  byte enables.
done  out  1  one-cycle completion pulse.
next_pc  out  XLEN  valid when done=1.
illegal  out  1  valid when done=1.

Behaviour:
- Reset: any time rst=0, state goes to IDLE asynchronously. Every output is 0 except in_ready=1. A reset in the middle of an operation aborts it with no rf/dm write.
- States: IDLE -> OPND -> EXEC -> {WB | MEM_RD -> LD_WB | MEM_WR} -> IDLE.
- IDLE: when in_valid=1, the control word is latched and rf_rd_addr0/1 are driven with rs1/rs2. in_valid is ignored in every other state.
- OPND: register A and B.
  - A = pc for auipc/jal; 0 for lui; rs1 data otherwise.
  - B = rs2 data for reg/brnch; imm otherwise.
  - fs = {fun7,fun3} for reg; {fun3==5 ? fun7 : 0, fun3} for imm; 4'b1000 (SUB) for brnch; 0 (ADD) otherwise.
- EXEC: fu_s and fu_flags are captured.
- Branch condition, by fun3:
  - 0 beq: Z.
  - 1 bne: !Z.
  - 4 blt: N^V.
  - 5 bge: !(N^V).
  - 6 bltu: !C.
  - 7 bgeu: C.
  - 2 or 3: illegal.
- next_pc:
  - Taken branch: pc+imm (internal adder). Not taken: pc+4.
  - jal: fu_s.
  - jalr: (rs1+imm) with bit 0 cleared; the jalr target is computed by the FunctionUnit with A=rs1.
  - All others: pc+4.
- Link value pc+4 is written for jal/jalr.
- Memory addressing:
  - Word address = fu_s[DMEM_AW+OFF-1 : OFF], where OFF = log2(XLEN/8). Byte offset = fu_s[OFF-1:0].
  - Access must be naturally aligned. Misaligned or unsupported fun3 gives illegal=1 and no write.
  - Supported loads: LB/LH/LW/LBU/LHU. LD/LWU are supported only when XLEN=64.
- MEM_RD: dm_rd_addr is driven. LD_WB selects the lane, then sign- or zero-extends it by fun3.
- MEM_WR: dm_we=1 for exactly one cycle. rs2 is shifted into the lane and dm_wr_be is set, e.g. SB at offset 2 gives be=4'b0100.
- Writeback: rf_we is asserted for one cycle in WB/LD_WB. It is suppressed for store, branch, illegal, or rd=0.
- done pulses in the last state (WB, LD_WB or MEM_WR).
  - Latency from the accepting edge to done: ALU/branch/jump 3 cycles; store 3 cycles; load 4 cycles.
- inst_type>8 goes EXEC->WB with illegal=1, no writes, next_pc=pc+4.
- Back-to-back operation: in_ready rises in the cycle after done, so throughput is one operation per 4 or 5 cycles.

Test Plan:
1. Reset: assert rst=0 mid-EXEC of an ADD -> outputs go 0 and in_ready=1 immediately; no rf_we ever seen.
2. reg ADD, rs1=5, rs2=7, rd=3 -> fu_fs=0; done 3 cycles after accept; rf_we=1, rf_wr_addr=3, rf_wr_din=12, next_pc=pc+4.
3. Load LB, rs1=0x100, imm=3, dm_rd_dout=0x80FF_1234 -> dm_rd_addr=0x40; rf_wr_din=0xFFFF_FF80; done at cycle 4. The same stimulus as LBU -> 0x80.
4. Store SH, addr=0x102, rs2=0xABCD -> dm_wr_addr=0x40, dm_wr_be=4'b1100, dm_wr_din=0xABCD_0000. With addr=0x101 -> illegal=1 and dm_we stays 0.
5. Branches at pc=0x20, imm=0x10:
   - BLT with rs1=-1, rs2=1 -> next_pc=0x30.
   - BLTU with the same operands -> next_pc=0x24.
   - JALR with rd=1, rs1=0x41, imm=0 -> next_pc=0x40, rf_wr_din=0x24.
6. inst_type=9 -> illegal=1, no writes. ADD with rd=0 -> rf_we=0. in_valid held during busy -> only one op accepted.
